ahb_slave_arbiter: RTL and testbench



---
 rtl/ahb_slave_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// AHB slave-side arbiter: picks one of MASTER_NUM requesting masters for a
// shared slave, round-robin, with burst protection and a beat quota that
// forces a yield at the next NONSEQ once the owner has used MAX_BEATS beats.

package AHB_package;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;
endpackage

module ahb_slave_arbiter
  import AHB_package::*;
#(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned MS_W       = $clog2(MASTER_NUM),
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hreq,
  input  htrans_type            htrans_m [MASTER_NUM],
  input  logic                  hreadyout_s,
  output logic                  hsel_s,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MS_W-1:0]       haddr_sel,
  output logic [MS_W-1:0]       hdata_sel,
  output logic [MASTER_NUM-1:0] hready_m
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

  arb_state_e            r_state;
  logic [MASTER_NUM-1:0] r_grant;
  logic [MS_W-1:0]       r_owner;
  logic [MS_W-1:0]       r_ptr;
  logic [MS_W-1:0]       r_dsel;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dvalid;

  htrans_type            w_trans;
  logic                  w_own;
  logic                  w_own_req;
  logic                  w_active;
  logic                  w_others;
  logic                  w_release;
  logic                  w_yield;
  logic                  w_sel;
  logic [MASTER_NUM-1:0] w_mask;
  logic [MS_W-1:0]       w_idx;
  logic [MS_W-1:0]       w_win;
  logic                  w_win_found;
  logic [MASTER_NUM-1:0] w_win_oh;
  logic [MS_W-1:0]       w_ptr_next;

  // Owner's transfer classification; yield is computed independent of hreadyout_s
  always_comb begin
    w_own     = (r_state == ARB_OWN);
    w_trans   = htrans_m[r_owner];
    w_own_req = hreq[r_owner];
    w_active  = w_own && w_own_req && ((w_trans == NONSEQ) || (w_trans == SEQ));
    w_others  = |(hreq & ~r_grant);
    w_release = w_own && (!w_own_req || (w_trans == IDLE));
    // SEQ/BUSY never yield, so a burst is never split
    w_yield   = w_own && w_own_req && (w_trans == NONSEQ) &&
                (r_cnt == CNT_W'(MAX_BEATS)) && w_others;
    w_sel     = w_active && !w_yield;
    // A yielding owner is excluded from the next pick
    w_mask    = w_yield ? (hreq & ~r_grant) : hreq;
  end

  // Round-robin pick: first masked requester at or after r_ptr
  always_comb begin
    w_idx       = '0;
    w_win       = '0;
    w_win_found = 1'b0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      w_idx = MS_W'((32'(r_ptr) + i) % MASTER_NUM);
      if (!w_win_found && w_mask[w_idx]) begin
        w_win       = w_idx;
        w_win_found = 1'b1;
      end
    end
    w_win_oh   = MASTER_NUM'(1) << w_win;
    w_ptr_next = MS_W'((32'(w_win) + 32'd1) % MASTER_NUM);
  end

  // Arbitration FSM with registered grant, pointer, beat counter and data-phase owner
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_dsel   <= '0;
      r_cnt    <= '0;
      r_dvalid <= 1'b0;
    end else if (hreadyout_s) begin
      if (w_sel) begin
        r_dvalid <= 1'b1;
        r_dsel   <= r_owner;
      end else begin
        r_dvalid <= 1'b0;
      end
      unique case (r_state)
        ARB_IDLE: begin
          if (w_win_found) begin
            r_state <= ARB_OWN;
            r_grant <= w_win_oh;
            r_owner <= w_win;
            r_ptr   <= w_ptr_next;
            r_cnt   <= '0;
          end
        end
        ARB_OWN: begin
          if (w_release || w_yield) begin
            // Hand over at this same edge so there is no dead cycle
            if (w_win_found) begin
              r_grant <= w_win_oh;
              r_owner <= w_win;
              r_ptr   <= w_ptr_next;
            end else begin
              r_state <= ARB_IDLE;
              r_grant <= '0;
            end
            r_cnt <= '0;
          end else if (w_sel && (r_cnt != CNT_W'(MAX_BEATS))) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Slave select and per-master HREADY; a yielding owner is stalled
  always_comb begin
    hsel_s   = w_sel && !hreset;
    hready_m = '1;
    if (!hreset) begin
      for (int unsigned m = 0; m < MASTER_NUM; m++) begin
        if (w_yield && r_grant[m]) begin
          hready_m[m] = 1'b0;
        end else if (r_grant[m] || (r_dvalid && (r_dsel == MS_W'(m)))) begin
          hready_m[m] = hreadyout_s;
        end else begin
          hready_m[m] = !hreq[m];
        end
      end
    end
  end

  assign hgrant    = r_grant;
  assign haddr_sel = r_owner;
  assign hdata_sel = r_dsel;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Self-checking bench for ahb_slave_arbiter: directed scenarios followed by
// random traffic, all checked against a tenure-level reference model.

module tb_ahb_slave_arbiter;
  import AHB_package::*;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hreq;
  htrans_type htrans_m [N];
  logic       hreadyout_s;
  logic       hsel_s;
  logic [3:0] hgrant;
  logic [1:0] haddr_sel;
  logic [1:0] hdata_sel;
  logic [3:0] hready_m;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current owner (-1 = none), rotation start, beats used,
  // last address-mux index, and data-phase owner.
  int m_own   = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_addr  = 0;
  int m_dsel  = 0;
  bit m_dv    = 1'b0;

  ahb_slave_arbiter #(
    .MASTER_NUM (N),
    .MS_W       (2),
    .MAX_BEATS  (MB)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hreq        (hreq),
    .htrans_m    (htrans_m),
    .hreadyout_s (hreadyout_s),
    .hsel_s      (hsel_s),
    .hgrant      (hgrant),
    .haddr_sel   (haddr_sel),
    .hdata_sel   (hdata_sel),
    .hready_m    (hready_m)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic bit m_yield();
    logic [3:0] oth;
    if (m_own < 0) return 1'b0;
    oth = hreq;
    oth[m_own] = 1'b0;
    return hreq[m_own] && (htrans_m[m_own] == NONSEQ) && (m_beats == MB) && (oth != 4'b0);
  endfunction

  function automatic bit m_sel();
    if (m_own < 0) return 1'b0;
    return hreq[m_own] && ((htrans_m[m_own] == NONSEQ) || (htrans_m[m_own] == SEQ)) &&
           !m_yield();
  endfunction

  task automatic give(input int w);
    m_own   = w;
    m_addr  = w;
    m_ptr   = (w + 1) % N;
    m_beats = 0;
  endtask

  task automatic model_check();
    logic [3:0] eg;
    logic [3:0] er;
    bit y;
    y  = m_yield();
    eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
    for (int m = 0; m < N; m++) begin
      if (hreset) er[m] = 1'b1;
      else if (y && m == m_own) er[m] = 1'b0;
      else if (m == m_own || (m_dv && m == m_dsel)) er[m] = hreadyout_s;
      else er[m] = !hreq[m];
    end
    chk("hgrant", 32'(hgrant), 32'(eg));
    chk("haddr_sel", 32'(haddr_sel), 32'(m_addr));
    chk("hdata_sel", 32'(hdata_sel), 32'(m_dsel));
    chk("hsel_s", 32'(hsel_s), hreset ? 32'd0 : 32'(m_sel()));
    chk("hready_m", 32'(hready_m), 32'(er));
  endtask

  task automatic model_update();
    bit y;
    bit s;
    bit rel;
    logic [3:0] mask;
    int w;
    if (hreset) begin
      m_own = -1; m_ptr = 0; m_beats = 0; m_addr = 0; m_dsel = 0; m_dv = 1'b0;
      return;
    end
    if (!hreadyout_s) return;
    y = m_yield();
    s = m_sel();
    if (s) begin
      m_dv = 1'b1;
      m_dsel = m_own;
      if (m_beats < MB) m_beats++;
    end else begin
      m_dv = 1'b0;
    end
    if (m_own < 0) begin
      w = winner(hreq);
      if (w >= 0) give(w);
    end else begin
      rel = !hreq[m_own] || (htrans_m[m_own] == IDLE);
      if (rel || y) begin
        mask = hreq;
        if (y) mask[m_own] = 1'b0;
        w = winner(mask);
        if (w >= 0) give(w);
        else begin
          m_own = -1;
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic probe();
    #4;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge hclk);
    #1;
  endtask

  task automatic cyc();
    probe();
    tick();
  endtask

  task automatic drive(input logic [3:0] rq, input htrans_type t0, input htrans_type t1,
                       input htrans_type t2, input htrans_type t3, input logic rdy);
    hreq        = rq;
    htrans_m[0] = t0;
    htrans_m[1] = t1;
    htrans_m[2] = t2;
    htrans_m[3] = t3;
    hreadyout_s = rdy;
  endtask

  initial begin
    // Reset held two cycles with every master requesting
    hreset = 1'b1;
    drive(4'b1111, NONSEQ, NONSEQ, NONSEQ, NONSEQ, 1'b1);
    @(posedge hclk);
    #1;
    tick();
    probe();
    chk("rst_hgrant", 32'(hgrant), 32'd0);
    chk("rst_hsel", 32'(hsel_s), 32'd0);
    chk("rst_hready", 32'(hready_m), 32'hF);
    tick();
    hreset = 1'b0;

    // Single request: one wait cycle, then grant, then data phase
    drive(4'b0100, IDLE, IDLE, NONSEQ, IDLE, 1'b1);
    probe();
    chk("single_wait", 32'(hready_m[2]), 32'd0);
    tick();
    probe();
    chk("single_grant", 32'(hgrant), 32'h4);
    chk("single_addr", 32'(haddr_sel), 32'd2);
    chk("single_hsel", 32'(hsel_s), 32'd1);
    tick();
    drive(4'b0000, IDLE, IDLE, IDLE, IDLE, 1'b1);
    probe();
    chk("single_dsel", 32'(hdata_sel), 32'd2);
    tick();

    // Contention from idle with pointer at 0, gapless handover
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    drive(4'b0011, NONSEQ, NONSEQ, IDLE, IDLE, 1'b1);
    cyc();
    probe();
    chk("cont_m0", 32'(hgrant), 32'h1);
    tick();
    drive(4'b0011, IDLE, NONSEQ, IDLE, IDLE, 1'b1);
    cyc();
    probe();
    chk("cont_m1", 32'(hgrant), 32'h2);
    chk("cont_m1_hsel", 32'(hsel_s), 32'd1);
    tick();

    // INCR8 held to completion, beat quota exceeded only by SEQ beats
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    drive(4'b1001, NONSEQ, IDLE, IDLE, NONSEQ, 1'b1);
    cyc();
    for (int b = 0; b < 8; b++) begin
      drive(4'b1001, (b == 0) ? NONSEQ : SEQ, IDLE, IDLE, NONSEQ, 1'b1);
      probe();
      chk("burst_hold", 32'(hgrant), 32'h1);
      chk("burst_hsel", 32'(hsel_s), 32'd1);
      tick();
    end
    drive(4'b1001, IDLE, IDLE, IDLE, NONSEQ, 1'b1);
    cyc();
    probe();
    chk("burst_next", 32'(hgrant), 32'h8);
    tick();

    // Fairness: fifth NONSEQ is refused and ownership moves on
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    drive(4'b0110, IDLE, NONSEQ, NONSEQ, IDLE, 1'b1);
    cyc();
    for (int b = 0; b < MB; b++) begin
      probe();
      chk("fair_accept", 32'(hsel_s), 32'd1);
      tick();
    end
    probe();
    chk("fair_hsel", 32'(hsel_s), 32'd0);
    chk("fair_stall", 32'(hready_m[1]), 32'd0);
    tick();
    probe();
    chk("fair_grant", 32'(hgrant), 32'h4);
    tick();

    // Wait states mid-burst freeze everything
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    drive(4'b0001, NONSEQ, IDLE, IDLE, IDLE, 1'b1);
    cyc();
    cyc();
    drive(4'b0001, SEQ, IDLE, IDLE, IDLE, 1'b1);
    cyc();
    drive(4'b0001, SEQ, IDLE, IDLE, IDLE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      probe();
      chk("wait_grant", 32'(hgrant), 32'h1);
      chk("wait_dsel", 32'(hdata_sel), 32'd0);
      chk("wait_ready", 32'(hready_m[0]), 32'd0);
      tick();
    end
    drive(4'b0001, SEQ, IDLE, IDLE, IDLE, 1'b1);
    probe();
    chk("wait_resume", 32'(hready_m[0]), 32'd1);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      hreset      = ($urandom_range(0, 49) == 0);
      hreq        = 4'($urandom_range(0, 15));
      for (int m = 0; m < N; m++) htrans_m[m] = htrans_type'(2'($urandom_range(0, 3)));
      hreadyout_s = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
